// File: rtl/block_transmit_sd.sv
// block_transmit_sd: sends one 512-byte block from the SDCard word cache to the
// card over MOSI in SPI mode. The frame is gap, start token, data, then CRC16.
// Afterwards it reads the card's data-response token and waits out the busy period.
module block_transmit_sd #(
    parameter int respTimeout = 64
) (
    input  logic        clk400,
    input  logic        reset,
    input  logic        enable,
    input  logic        SDin,
    input  logic [15:0] cacheValue,
    output logic        SDout,
    output logic [7:0]  cacheAddress,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  status
);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        TOKEN,
        DATA,
        CRC,
        RESP,
        BUSY,
        DONE
    } state_t;

    localparam logic [11:0] RESP_LAST = 12'(respTimeout - 1);
    localparam logic [15:0] CRC_POLY  = 16'h1021;

    state_t      state;
    logic [11:0] count;
    logic [15:0] shifter;
    logic [15:0] crc;
    logic        resp_started;
    logic        tx_bit;
    logic        crc_feedback;
    logic [15:0] crc_next;

    // Next CRC16-CCITT value when the current data bit goes out on the wire
    always_comb begin
        crc_feedback = crc[15] ^ shifter[15];
        crc_next     = {crc[14:0], 1'b0} ^ (crc_feedback ? CRC_POLY : 16'h0000);
    end

    // Select the MOSI bit for the current cycle; the line idles high outside the frame
    always_comb begin
        tx_bit = 1'b1;
        case (state)
            TOKEN:   tx_bit = (count[2:0] != 3'd7);
            DATA:    tx_bit = shifter[15];
            CRC:     tx_bit = crc[15];
            default: tx_bit = 1'b1;
        endcase
    end

    // Main transmit/response sequencer with registered outputs
    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            shifter      <= '0;
            crc          <= '0;
            resp_started <= 1'b0;
            cacheAddress <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            status       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        error        <= 1'b0;
                        status       <= '0;
                        crc          <= '0;
                        cacheAddress <= '0;
                        count        <= '0;
                        busy         <= 1'b1;
                        state        <= GAP;
                    end
                end

                GAP: begin
                    if (count == 12'd7) begin
                        count <= '0;
                        state <= TOKEN;
                    end else begin
                        count <= count + 12'd1;
                    end
                end

                TOKEN: begin
                    if (count == 12'd7) begin
                        shifter      <= cacheValue;
                        cacheAddress <= 8'd1;
                        count        <= '0;
                        state        <= DATA;
                    end else begin
                        count <= count + 12'd1;
                    end
                end

                DATA: begin
                    crc <= crc_next;
                    if (count == 12'd4095) begin
                        count <= '0;
                        state <= CRC;
                    end else begin
                        count <= count + 12'd1;
                        if (count[3:0] == 4'd15) begin
                            shifter <= cacheValue;
                            if (cacheAddress != 8'd255) begin
                                cacheAddress <= cacheAddress + 8'd1;
                            end
                        end else begin
                            shifter <= {shifter[14:0], 1'b0};
                        end
                    end
                end

                CRC: begin
                    crc <= {crc[14:0], 1'b0};
                    if (count == 12'd15) begin
                        count        <= '0;
                        resp_started <= 1'b0;
                        state        <= RESP;
                    end else begin
                        count <= count + 12'd1;
                    end
                end

                RESP: begin
                    if (!resp_started) begin
                        if (!SDin) begin
                            resp_started <= 1'b1;
                            count        <= '0;
                        end else if (count == RESP_LAST) begin
                            status <= 3'b111;
                            error  <= 1'b1;
                            count  <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            count <= count + 12'd1;
                        end
                    end else begin
                        if (count == 12'd3) begin
                            error        <= (status != 3'b010);
                            resp_started <= 1'b0;
                            count        <= '0;
                            state        <= BUSY;
                        end else begin
                            status <= {status[1:0], SDin};
                            count  <= count + 12'd1;
                        end
                    end
                end

                BUSY: begin
                    if (SDin) begin
                        count <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    count <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    count <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // MOSI changes on the falling edge so the card sees a stable bit at the next rising edge
    always_ff @(negedge clk400 or posedge reset) begin
        if (reset) begin
            SDout <= 1'b1;
        end else begin
            SDout <= tx_bit;
        end
    end

endmodule

// File: doc/block_transmit_sd.md
# block_transmit_sd

Sends one 512-byte data block from the SDCard module's 256×16-bit cache to the card over MOSI in SPI mode, as used by single-block write (CMD24). Emits the gap, start token, data, and CRC16. Then reads the card's data-response token and waits out the busy period on MISO. It sits beside the block receiver inside the SDCard module and shares its cache, clock and reset.

## Interface
Parameters:
- respTimeout, 64: maximum bit cycles to wait for a data-response start bit.

Ports:
- clk400  input  1  SD/SPI bit clock; all state on rising edge except SDout.
- reset  input  1  asynchronous, active-high.
- enable  input  1  start request, sampled in IDLE only.
- SDin  input  1  MISO from card, sampled on rising edge.
- cacheValue  input  16  cache read data, asynchronous w.r.t. cacheAddress (same cycle).
- SDout  output  1  MOSI to card.
- cacheAddress  output  8  cache word address.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  response was not "accepted", or timeout.
- status  output  3  captured response status bits.

## Operation
- States: IDLE, GAP, TOKEN, DATA, CRC, RESP, BUSY, DONE. A shared 12-bit bit counter is cleared on every state entry.
- IDLE:
  - SDout=1.
  - On enable=1, clear error, status, CRC, and cacheAddress, then go to GAP.
  - enable in any other state is ignored.
- GAP: 8 bit cycles of SDout=1 (Nwr), then TOKEN.
- TOKEN:
  - 8 bits of 0xFE, MSB first.
  - In its last bit cycle, load the shifter with cacheValue (address 0) and set cacheAddress←1.
- DATA:
  - 4096 bits, shifter MSB first, so word 0 bit 15 goes first.
  - When count[3:0]==15 and count≠4095, load shifter←cacheValue and cacheAddress←cacheAddress+1.
  - cacheAddress holds 255 after the final load; no wrap.
- CRC16-CCITT over the 4096 data bits only:
  - Polynomial x^16+x^12+x^5+1, initial value 0x0000.
  - Update each DATA bit with the transmitted bit.
- CRC state: 16 bits of the CRC register, MSB first, shifted out. Then RESP.
- RESP:
  - SDout=1.
  - Wait for SDin==0 (start bit). Then capture the next 3 SDin bits into status, MSB first. Skip 1 end-bit cycle, then go to BUSY.
  - If respTimeout cycles elapse with no start bit: status=3'b111, error=1, go to DONE (skip BUSY).
- Response decode: error=1 unless status==3'b010 (accepted). Examples: 101 = CRC reject, 110 = write error.
- BUSY:
  - SDout=1. Stay while SDin==0; the first cycle with SDin==1 goes to DONE.
  - No timeout; a higher level uses reset to abort.
- DONE: done=1 for exactly this one cycle, then IDLE. error and status hold until the next accepted enable.

## Timing
- Reset values: SDout=1, cacheAddress=0, busy=0, done=0, error=0, status=0, state IDLE, counter 0, CRC 0.
- Reset mid-operation returns to IDLE immediately. The card sees MOSI high; nothing resumes.
- SDout is a register updated on the falling edge of clk400 from the bit selected by the rising-edge logic. The bit for cycle n is valid from falling edge n to falling edge n+1, and the card samples it at rising edge n+1.
- Latency: enable sampled at rising edge E.
  - GAP occupies cycles E+1..E+8.
  - Token first bit in cycle E+9; data first bit in cycle E+17.
  - CRC first bit in cycle E+4113; last CRC bit in cycle E+4128.
  - RESP begins in cycle E+4129.
- Minimum total: if the start bit arrives at the first RESP cycle and SDin is already high after the end bit, done rises at E+4135.
- Cache: cacheValue must reflect cacheAddress combinationally in the load cycle. Loads happen in the token's last bit, then data count 15, 31, …, 4079.
- Counter width: 12 bits covers 0..4095 in DATA. The counter never overflows in other states (max respTimeout−1).

## Test plan
- Cache words all 0x0000, card responds 0x05 (xxx00101) immediately, no busy:
  - MOSI reads 8×1, FE, 4096 zeros, CRC 0x0000.
  - status=010, error=0, done one cycle at E+4135.
- Cache word i = {i[7:0], ~i[7:0]}:
  - MOSI data stream equals words 0..255 MSB first.
  - cacheAddress steps 0→255 at count 15 boundaries.
  - Transmitted CRC matches the reference CRC16-CCITT of the stream.
- Card response 0x0B (status 101):
  - error=1, status=101; busy is still waited out before done.
- MISO held high throughout RESP:
  - After 64 cycles status=111, error=1, done pulses, no BUSY cycles.
- Busy held low for 100 cycles after the response:
  - done rises exactly 1 cycle after SDin returns high; busy=1 throughout.
- Reset asserted mid-DATA (count 2000):
  - All outputs return to reset values asynchronously.
  - enable=1 held during active states is ignored; a new enable afterward restarts from GAP with cacheAddress 0.
